imem_loader_arb: RTL and testbench

IMEM_LOADER_ARB -- requirements
Module: imem_loader_arb

---
 rtl/imem_loader_arb.sv | 147 ++++++++++++++
 tb/tb_imem_loader_arb.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_loader_arb.sv
// Arbitrates one byte-wide instruction memory between a 4-byte big-endian fetcher and a word loader.
// Latency: fetch_valid/ld_done pulse in the cycle after the 4th byte edge; one IDLE cycle between jobs.
// Backpressure: ld_ready is high only in IDLE; loads win over fetches; a waiting requester holds its request.
module imem_loader_arb #(
  parameter int ADDRESS_WIDTH = 32,
  parameter int DATA_WIDTH    = 8,
  parameter int MEM_AW        = 10
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     fetch_req,
  input  logic [ADDRESS_WIDTH-1:0] fetch_addr,
  input  logic                     fetch_flush,
  output logic                     fetch_valid,
  output logic [31:0]              fetch_instr,
  input  logic                     ld_valid,
  input  logic [ADDRESS_WIDTH-1:0] ld_addr,
  input  logic [31:0]              ld_data,
  output logic                     ld_ready,
  output logic                     ld_done,
  output logic [MEM_AW-1:0]        mem_addr,
  output logic                     mem_we,
  output logic [DATA_WIDTH-1:0]    mem_wdata,
  input  logic [DATA_WIDTH-1:0]    mem_rdata
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    LOAD  = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [1:0]        cnt_q, cnt_d;
  logic [MEM_AW-1:0] base_q, base_d;
  logic [31:0]       data_q, data_d;
  logic [23:0]       asm_q, asm_d;
  logic [31:0]       instr_q, instr_d;
  logic              fetch_valid_q, fetch_valid_d;
  logic              ld_done_q, ld_done_d;
  logic [7:0]        ld_byte;

  // Address bits above the array index are ignored: the array wraps modulo 2^MEM_AW.
  logic unused_addr_hi;
  assign unused_addr_hi = ^{fetch_addr[ADDRESS_WIDTH-1:MEM_AW], ld_addr[ADDRESS_WIDTH-1:MEM_AW]};

  // Loader byte for the current count, most significant byte first.
  always_comb begin
    ld_byte = data_q[31:24];
    case (cnt_q)
      2'd0: ld_byte = data_q[31:24];
      2'd1: ld_byte = data_q[23:16];
      2'd2: ld_byte = data_q[15:8];
      2'd3: ld_byte = data_q[7:0];
      default: ld_byte = data_q[31:24];
    endcase
  end

  // ld_ready depends on state alone so the loader never sees a combinational path from its own valid.
  assign ld_ready    = (state_q == IDLE);
  assign fetch_valid = fetch_valid_q;
  assign fetch_instr = instr_q;
  assign ld_done     = ld_done_q;

  // Next-state, datapath updates and memory port drive.
  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    base_d        = base_q;
    data_d        = data_q;
    asm_d         = asm_q;
    instr_d       = instr_q;
    fetch_valid_d = 1'b0;
    ld_done_d     = 1'b0;
    mem_we        = 1'b0;
    mem_addr      = '0;
    mem_wdata     = '0;
    case (state_q)
      IDLE: begin
        if (ld_valid) begin
          state_d = LOAD;
          base_d  = ld_addr[MEM_AW-1:0];
          data_d  = ld_data;
          cnt_d   = 2'd0;
        end else if (fetch_req && !fetch_flush) begin
          state_d = FETCH;
          base_d  = fetch_addr[MEM_AW-1:0];
          cnt_d   = 2'd0;
        end
      end
      FETCH: begin
        mem_addr = base_q + MEM_AW'(cnt_q);
        if (fetch_flush) begin
          // Partial assembly is discarded; the visible word is only replaced on completion.
          state_d = IDLE;
          cnt_d   = 2'd0;
        end else begin
          asm_d = {asm_q[15:0], mem_rdata[7:0]};
          cnt_d = cnt_q + 2'd1;
          if (cnt_q == 2'd3) begin
            state_d       = IDLE;
            instr_d       = {asm_q, mem_rdata[7:0]};
            fetch_valid_d = 1'b1;
          end
        end
      end
      LOAD: begin
        mem_we    = 1'b1;
        mem_addr  = base_q + MEM_AW'(cnt_q);
        mem_wdata = DATA_WIDTH'(ld_byte);
        cnt_d     = cnt_q + 2'd1;
        if (cnt_q == 2'd3) begin
          state_d   = IDLE;
          ld_done_d = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State and datapath registers; reset abandons any transaction without a completion pulse.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      cnt_q         <= 2'd0;
      base_q        <= '0;
      data_q        <= '0;
      asm_q         <= '0;
      instr_q       <= '0;
      fetch_valid_q <= 1'b0;
      ld_done_q     <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      base_q        <= base_d;
      data_q        <= data_d;
      asm_q         <= asm_d;
      instr_q       <= instr_d;
      fetch_valid_q <= fetch_valid_d;
      ld_done_q     <= ld_done_d;
    end
  end

endmodule

// File: tb/tb_imem_loader_arb.sv
// Directed bench for imem_loader_arb with a behavioural 1 KiB byte memory.
// Inputs are driven and outputs sampled 1 ns after each rising edge.
// Each scenario task carries its own inline comparisons.
module tb_imem_loader_arb;

  logic        clk;
  logic        rst;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_flush;
  logic        fetch_valid;
  logic [31:0] fetch_instr;
  logic        ld_valid;
  logic [31:0] ld_addr;
  logic [31:0] ld_data;
  logic        ld_ready;
  logic        ld_done;
  logic [9:0]  mem_addr;
  logic        mem_we;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  logic [7:0]  mem [0:1023];

  int n_tests = 0;
  int n_fail  = 0;

  imem_loader_arb #(.ADDRESS_WIDTH(32), .DATA_WIDTH(8), .MEM_AW(10)) dut (
    .clk         (clk),
    .rst         (rst),
    .fetch_req   (fetch_req),
    .fetch_addr  (fetch_addr),
    .fetch_flush (fetch_flush),
    .fetch_valid (fetch_valid),
    .fetch_instr (fetch_instr),
    .ld_valid    (ld_valid),
    .ld_addr     (ld_addr),
    .ld_data     (ld_data),
    .ld_ready    (ld_ready),
    .ld_done     (ld_done),
    .mem_addr    (mem_addr),
    .mem_we      (mem_we),
    .mem_wdata   (mem_wdata),
    .mem_rdata   (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  assign mem_rdata = mem[mem_addr];

  always @(posedge clk) begin
    if (mem_we) mem[mem_addr] = mem_wdata;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Full fetch: accept edge, four byte cycles with the wrapped address, then the valid pulse.
  task automatic run_fetch(input logic [31:0] addr, input logic [31:0] exp, input logic hold_req);
    logic [9:0] ea;
    fetch_addr = addr;
    fetch_req  = 1'b1;
    tick();
    if (!hold_req) fetch_req = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = addr[9:0] + 10'(i);
      n_tests++;
      if (mem_addr !== ea || mem_we !== 1'b0 || fetch_valid !== 1'b0 || ld_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL fetch_byte%0d @%h: addr=%h we=%b vld=%b rdy=%b, want addr=%h we=0 vld=0 rdy=0",
                 i, addr, mem_addr, mem_we, fetch_valid, ld_ready, ea);
      end
      tick();
    end
    n_tests++;
    if (fetch_valid !== 1'b1 || fetch_instr !== exp || ld_ready !== 1'b1 || mem_addr !== 10'h0) begin
      n_fail++;
      $display("FAIL fetch_done @%h: vld=%b instr=%h rdy=%b addr=%h, want vld=1 instr=%h rdy=1 addr=000",
               addr, fetch_valid, fetch_instr, ld_ready, mem_addr, exp);
    end
  endtask

  // Full load: four write cycles MSB first, then the done pulse.
  task automatic run_load(input logic [31:0] addr, input logic [31:0] data);
    logic [9:0] ea;
    logic [7:0] eb;
    logic [31:0] d;
    d        = data;
    ld_addr  = addr;
    ld_data  = data;
    ld_valid = 1'b1;
    n_tests++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_ready_idle: ld_ready=%b want 1", ld_ready);
    end
    tick();
    ld_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      ea = addr[9:0] + 10'(i);
      eb = d[31-8*i -: 8];
      n_tests++;
      if (mem_we !== 1'b1 || mem_addr !== ea || mem_wdata !== eb || ld_done !== 1'b0) begin
        n_fail++;
        $display("FAIL load_byte%0d @%h: we=%b addr=%h wdata=%h done=%b, want we=1 addr=%h wdata=%h done=0",
                 i, addr, mem_we, mem_addr, mem_wdata, ld_done, ea, eb);
      end
      tick();
    end
    n_tests++;
    if (ld_done !== 1'b1 || mem_we !== 1'b0 || ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL load_done @%h: done=%b we=%b rdy=%b, want done=1 we=0 rdy=1", addr, ld_done, mem_we, ld_ready);
    end
  endtask

  task automatic test_reset();
    n_tests++;
    if (fetch_valid !== 1'b0 || fetch_instr !== 32'h0 || ld_done !== 1'b0 ||
        mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 8'h0) begin
      n_fail++;
      $display("FAIL reset_outputs: vld=%b instr=%h done=%b we=%b addr=%h wdata=%h, want all zero",
               fetch_valid, fetch_instr, ld_done, mem_we, mem_addr, mem_wdata);
    end
    rst = 1'b0;
    tick();
    n_tests++;
    if (ld_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: ld_ready=%b want 1", ld_ready);
    end
  endtask

  task automatic test_fetch();
    run_fetch(32'h10, 32'h1300_0593, 1'b0);
    tick();
    n_tests++;
    if (fetch_valid !== 1'b0 || fetch_instr !== 32'h1300_0593) begin
      n_fail++;
      $display("FAIL fetch_hold: vld=%b instr=%h, want vld=0 instr=13000593", fetch_valid, fetch_instr);
    end
  endtask

  task automatic test_load();
    run_load(32'h20, 32'hDEAD_BEEF);
    tick();
    n_tests++;
    if (ld_done !== 1'b0 || {mem[32], mem[33], mem[34], mem[35]} !== 32'hDEAD_BEEF) begin
      n_fail++;
      $display("FAIL load_mem: done=%b mem=%h%h%h%h, want done=0 mem=deadbeef",
               ld_done, mem[32], mem[33], mem[34], mem[35]);
    end
    run_fetch(32'h20, 32'hDEAD_BEEF, 1'b0);
    tick();
  endtask

  task automatic test_priority();
    fetch_addr = 32'h10;
    fetch_req  = 1'b1;
    run_load(32'h40, 32'h0102_0304);
    // The ld_done cycle is IDLE with fetch_req still high, so the next edge accepts the fetch.
    run_fetch(32'h10, 32'h1300_0593, 1'b0);
    tick();
    n_tests++;
    if ({mem[64], mem[65], mem[66], mem[67]} !== 32'h0102_0304) begin
      n_fail++;
      $display("FAIL priority_mem: mem=%h%h%h%h want 01020304", mem[64], mem[65], mem[66], mem[67]);
    end
  endtask

  task automatic test_wrap();
    run_load(32'h400, 32'hC3D4_E5F6);
    tick();
    run_fetch(32'h3FE, 32'hA1B2_C3D4, 1'b0);
    tick();
  endtask

  task automatic test_flush();
    // fetch_instr currently holds a1b2c3d4 from the wrap fetch.
    fetch_addr = 32'h20;
    fetch_req  = 1'b1;
    tick();
    fetch_req = 1'b0;
    tick();
    tick();
    n_tests++;
    if (mem_addr !== 10'h022) begin
      n_fail++;
      $display("FAIL flush_cnt2: addr=%h want 022", mem_addr);
    end
    fetch_flush = 1'b1;
    tick();
    fetch_flush = 1'b0;
    n_tests++;
    if (ld_ready !== 1'b1 || fetch_valid !== 1'b0 || mem_addr !== 10'h0 || fetch_instr !== 32'hA1B2_C3D4) begin
      n_fail++;
      $display("FAIL flush_abort: rdy=%b vld=%b addr=%h instr=%h, want rdy=1 vld=0 addr=000 instr=a1b2c3d4",
               ld_ready, fetch_valid, mem_addr, fetch_instr);
    end
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (fetch_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL flush_no_valid%0d: vld=%b want 0", i, fetch_valid);
      end
    end
    // Flush in IDLE blocks acceptance.
    fetch_req   = 1'b1;
    fetch_flush = 1'b1;
    tick();
    fetch_req   = 1'b0;
    n_tests++;
    if (ld_ready !== 1'b1 || mem_addr !== 10'h0) begin
      n_fail++;
      $display("FAIL flush_idle_block: rdy=%b addr=%h, want rdy=1 addr=000", ld_ready, mem_addr);
    end
    // Flush held through a load is ignored.
    run_load(32'h60, 32'h5566_7788);
    fetch_flush = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    run_fetch(32'h10, 32'h1300_0593, 1'b1);
    // Valid cycle is IDLE: the held request with a new address is accepted at the next edge.
    run_fetch(32'h20, 32'hDEAD_BEEF, 1'b0);
    tick();
    run_load(32'h80, 32'hAABB_CCDD);
    run_load(32'h84, 32'h1122_3344);
    tick();
    n_tests++;
    if ({mem[128], mem[131], mem[132], mem[135]} !== 32'hAADD_1144) begin
      n_fail++;
      $display("FAIL b2b_mem: mem=%h%h%h%h want aadd1144", mem[128], mem[131], mem[132], mem[135]);
    end
  endtask

  task automatic test_reset_mid_load();
    ld_addr  = 32'h50;
    ld_data  = 32'h1122_3344;
    ld_valid = 1'b1;
    tick();
    ld_valid = 1'b0;
    tick();
    n_tests++;
    if (mem_addr !== 10'h051 || mem_we !== 1'b1) begin
      n_fail++;
      $display("FAIL rst_load_cnt1: addr=%h we=%b, want addr=051 we=1", mem_addr, mem_we);
    end
    // Let the cnt=1 byte land, then reset asynchronously.
    @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    n_tests++;
    if (mem_we !== 1'b0 || mem_addr !== 10'h0 || mem_wdata !== 8'h0 || ld_done !== 1'b0 ||
        fetch_valid !== 1'b0 || fetch_instr !== 32'h0) begin
      n_fail++;
      $display("FAIL rst_load_zero: we=%b addr=%h wdata=%h done=%b vld=%b instr=%h, want all zero",
               mem_we, mem_addr, mem_wdata, ld_done, fetch_valid, fetch_instr);
    end
    tick();
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      tick();
      n_tests++;
      if (ld_done !== 1'b0 || ld_ready !== 1'b1 || mem_we !== 1'b0) begin
        n_fail++;
        $display("FAIL rst_load_after%0d: done=%b rdy=%b we=%b, want done=0 rdy=1 we=0", i, ld_done, ld_ready, mem_we);
      end
    end
    n_tests++;
    if ({mem[80], mem[81], mem[82], mem[83]} !== 32'h1122_0000) begin
      n_fail++;
      $display("FAIL rst_load_mem: mem=%h%h%h%h want 11220000", mem[80], mem[81], mem[82], mem[83]);
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
    mem[16]   = 8'h13;
    mem[17]   = 8'h00;
    mem[18]   = 8'h05;
    mem[19]   = 8'h93;
    mem[1022] = 8'hA1;
    mem[1023] = 8'hB2;
    rst         = 1'b1;
    fetch_req   = 1'b0;
    fetch_addr  = 32'h0;
    fetch_flush = 1'b0;
    ld_valid    = 1'b0;
    ld_addr     = 32'h0;
    ld_data     = 32'h0;
    tick();
    tick();
    test_reset();
    test_fetch();
    test_load();
    test_priority();
    test_wrap();
    test_flush();
    test_back_to_back();
    test_reset_mid_load();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
